rr_hold_arbiter: RTL and testbench

//  Sequential round-robin arbiter. It sits downstream of N requesters and is the

---
 rtl/rr_hold_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_hold_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rr_hold_arbiter.sv
// Sequential round-robin arbiter with grant hold and optional hold limit.
// Registered one-hot grant plus encoded index; no combinational req->gnt path.
module rr_hold_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  localparam int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;

  logic [IW-1:0] w_rel_ptr;
  logic [IW-1:0] w_base;
  logic [IW-1:0] w_pick;
  logic          w_found;
  logic          w_release;

  // Modular add with an explicit wrap so non-power-of-2 N stays in range.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  assign w_rel_ptr = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
  // On release the new pointer takes effect for the pick made on the same edge.
  assign w_base    = (r_state == S_GRANT) ? w_rel_ptr : r_ptr;
  assign w_release = !req[r_idx] || ((MAX_HOLD != 0) && (r_hold == HOLD_LIM));

  // Scan from the farthest offset down so the nearest set bit to w_base wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_add(w_base, k)]) begin
        w_found = 1'b1;
        w_pick  = wrap_add(w_base, k);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset clears outputs without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // NOTE: every signal gets a default first so no path through this block
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = N'(1) << w_pick;
          w_idx_nxt   = w_pick;
          w_hold_nxt  = HW'(1);
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_rel_ptr;
          if (w_found) begin
            w_gnt_nxt  = N'(1) << w_pick;
            w_idx_nxt  = w_pick;
            w_hold_nxt = HW'(1);
          end else begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_hold_nxt  = '0;
          end
        end else if (r_hold != '1) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt       = r_gnt;
    gnt_idx   = r_idx;
    gnt_valid = (r_state == S_GRANT);
  end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter: one instance with MAX_HOLD=4 and one
// with unlimited hold; expected grants are hand-derived per step.
module tb_rr_hold_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req, req_b;
  logic [7:0] gnt, gnt_b;
  logic [2:0] gnt_idx, gnt_idx_b;
  logic       gnt_valid, gnt_valid_b;

  int n_total = 0;
  int n_bad   = 0;

  rr_hold_arbiter #(.N(8), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  rr_hold_arbiter #(.N(8), .MAX_HOLD(0)) u_dut_inf (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .gnt(gnt_b), .gnt_idx(gnt_idx_b), .gnt_valid(gnt_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_gnt(input string tag, input logic [7:0] exp_gnt, input logic [2:0] exp_idx);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".idx"}, 32'(gnt_idx), 32'(exp_idx));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(exp_gnt != 8'h00));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
      check("onehot0_b", 32'($onehot0(gnt_b)), 32'd1);
    end
  end

  initial begin
    logic [7:0] exp_g;
    int owner;
    rst_n = 1'b1;
    req   = 8'h00;
    req_b = 8'h00;
    #1 rst_n = 1'b0;
    repeat (2) step();
    check_gnt("reset", 8'h00, 3'd0);
    rst_n = 1'b1;
    step();
    check_gnt("idle_after_reset", 8'h00, 3'd0);

    // Basic handoff
    req = 8'h05;
    step();
    check_gnt("handoff0", 8'h01, 3'd0);
    req = 8'h04;
    step();
    check_gnt("handoff2", 8'h04, 3'd2);
    req = 8'h00;
    step();
    check_gnt("drop_idle", 8'h00, 3'd0);

    // Hold limit and rotation from ptr=3: 3,4,5,6,7,0,1,2 each for 4 cycles
    req = 8'hFF;
    step();
    for (int g = 0; g < 8; g++) begin
      owner = (3 + g) % 8;
      exp_g = 8'h01 << owner;
      for (int c = 0; c < 4; c++) begin
        check_gnt($sformatf("rot_g%0d_c%0d", g, c), exp_g, 3'(owner));
        step();
      end
    end
    check_gnt("rot_back_to3", 8'h08, 3'd3);

    // Release to idle, then ptr=4
    req = 8'h00;
    step();
    check_gnt("release_idle", 8'h00, 3'd0);
    req = 8'hFF;
    step();
    check_gnt("ptr4", 8'h10, 3'd4);

    // Wrap-around: owner 7 times out with req=81 -> owner 0
    req = 8'h80;
    step();
    check_gnt("to7", 8'h80, 3'd7);
    req = 8'h81;
    for (int c = 0; c < 3; c++) begin
      step();
      check_gnt($sformatf("hold7_c%0d", c), 8'h80, 3'd7);
    end
    step();
    check_gnt("wrap7to0", 8'h01, 3'd0);

    // Lone timed-out owner is regranted without a gap
    req = 8'h01;
    for (int c = 0; c < 6; c++) begin
      step();
      check_gnt($sformatf("regrant0_c%0d", c), 8'h01, 3'd0);
    end

    // Non-owner noise while owner 2 holds
    req = 8'h04;
    step();
    check_gnt("to2", 8'h04, 3'd2);
    for (int c = 0; c < 3; c++) begin
      req = (c % 2 == 1) ? 8'hAC : 8'h54;
      step();
      check_gnt($sformatf("noise_c%0d", c), 8'h04, 3'd2);
    end
    req = 8'hAC;
    step();
    check_gnt("noise_timeout", 8'h08, 3'd3);

    // Reset mid-operation
    req = 8'h20;
    step();
    check_gnt("to5", 8'h20, 3'd5);
    #2 rst_n = 1'b0;
    #1;
    check_gnt("async_reset", 8'h00, 3'd0);
    req = 8'h21;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_gnt("post_reset", 8'h01, 3'd0);
    req = 8'h00;

    // Unlimited hold: owner 0 keeps grant while req[7] waits
    req_b = 8'h01;
    step();
    check("inf_first", 32'(gnt_b), 32'h01);
    req_b = 8'h81;
    for (int c = 0; c < 100; c++) begin
      step();
      check($sformatf("inf_hold_c%0d", c), 32'(gnt_b), 32'h01);
    end
    req_b = 8'h80;
    step();
    check("inf_switch7", 32'(gnt_b), 32'h80);
    check("inf_idx7", 32'(gnt_idx_b), 32'd7);
    check("inf_valid", 32'(gnt_valid_b), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
